// File: rtl/cc1200_spi_master.sv
// SPI mode-0 master for the TI CC1200: header byte, optional data burst, status capture.
// Optional chip-ready wait with timeout is enabled by defining CC1200_SPI_RDY_WAIT_EN.
module cc1200_spi_master #(
  parameter int CLK_DIV     = 4,
  parameter int RDY_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] header,
  input  logic [7:0] len,
  input  logic [7:0] wr_data,
  output logic       wr_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] status,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       CS_n
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, SHIFT, CS_HOLD, CS_HIGH} state_t;

  localparam int DW       = $clog2(CLK_DIV);
  localparam int WAIT_MAX = (RDY_TIMEOUT > CLK_DIV) ? RDY_TIMEOUT : CLK_DIV;
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
`ifdef CC1200_SPI_RDY_WAIT_EN
  localparam logic [WW-1:0] WAIT_LAST = WW'(RDY_TIMEOUT - 1);
`else
  localparam logic [WW-1:0] WAIT_LAST = WW'(CLK_DIV - 1);
`endif

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    byte_cnt;
  logic [7:0]    len_q;
  logic          is_read;
  logic [6:0]    tx_sr;   // bits still to send after the one on MOSI
  logic [6:0]    rx_sr;
  logic [7:0]    rx_byte;

  assign rx_byte = {rx_sr, MISO};

  // NOTE: all state and outputs are flops written with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      wait_cnt    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      len_q       <= '0;
      is_read     <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      wr_req      <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      status      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      SCLK        <= 1'b0;
      MOSI        <= 1'b0;
      CS_n        <= 1'b1;
    end else begin
      // NOTE: pulse outputs default low here so each set below lasts exactly one cycle.
      wr_req   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q       <= len;
            is_read     <= header[7];
            MOSI        <= header[7];
            tx_sr       <= header[6:0];
            busy        <= 1'b1;
            CS_n        <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            state       <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
`ifdef CC1200_SPI_RDY_WAIT_EN
          if (!MISO) begin
            state <= SHIFT;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            MOSI        <= 1'b0;
            state       <= CS_HOLD;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
`else
          if (wait_cnt == WAIT_LAST) state <= SHIFT;
          else                       wait_cnt <= wait_cnt + WW'(1);
`endif
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            if (!SCLK) begin
              SCLK  <= 1'b1;
              rx_sr <= rx_byte[6:0];
              if (bit_cnt == 3'd7) begin
                if (byte_cnt == 8'd0) begin
                  status <= rx_byte;
                end else if (is_read) begin
                  rd_data  <= rx_byte;
                  rd_valid <= 1'b1;
                end
                // The last data byte of a write needs no further refill.
                if (!is_read && byte_cnt != len_q) wr_req <= 1'b1;
              end
            end else begin
              SCLK <= 1'b0;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                if (byte_cnt == len_q) begin
                  MOSI  <= 1'b0;
                  state <= CS_HOLD;
                end else begin
                  byte_cnt <= byte_cnt + 8'd1;
                  MOSI     <= ~is_read & wr_data[7];
                  tx_sr    <= is_read ? 7'd0 : wr_data[6:0];
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                MOSI    <= tx_sr[6];
                tx_sr   <= {tx_sr[5:0], 1'b0};
              end
            end
          end
        end
        CS_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            CS_n    <= 1'b1;
            state   <= CS_HIGH;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        CS_HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc1200_spi_master.sv
// Self-checking bench for cc1200_spi_master: table vectors, random transactions against a
// bit-level SPI slave/reference model, plus busy, done-cycle restart, ready-wait and reset sequences.
module tb_cc1200_spi_master;

  localparam int CLK_DIV     = 4;
  localparam int RDY_TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] header, len, wr_data;
  logic       wr_req, rd_valid, busy, done, timeout_err;
  logic [7:0] rd_data, status;
  logic       SCLK, MOSI, MISO, CS_n;

  cc1200_spi_master #(.CLK_DIV(CLK_DIV), .RDY_TIMEOUT(RDY_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .header(header), .len(len), .wr_data(wr_data),
    .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid), .status(status), .busy(busy),
    .done(done), .timeout_err(timeout_err), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS_n(CS_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Observation state, all written only by the stimulus process through tick().
  int   rises, cs_low, hp_err, mosi_err, sclk_cs_err, wr_cnt, done_cnt, run_len;
  bit   seen_tog;
  logic sclk_prev = 1'b0, mosi_prev = 1'b0;
  bit         got_mosi[$], exp_mosi[$];
  logic [7:0] got_rd[$], exp_rd[$], wr_q[$];
  logic [7:0] last_status;

  // Slave model: shifts out status then data bytes MSB first, advancing on SCLK falls.
  logic [0:255] miso_vec = '0;
  int           sl_n = 0;
  int           sl_idx = 0;
  bit           miso_hi = 1'b0;
  assign MISO = miso_hi ? 1'b1 : ((sl_idx < sl_n) ? miso_vec[sl_idx] : 1'b0);
  always @(negedge SCLK or posedge CS_n) begin
    if (CS_n) sl_idx = 0;
    else      sl_idx = sl_idx + 1;
  end

  typedef struct {
    string            nm;
    logic [7:0]       h;
    logic [7:0]       l;
    logic [0:7][7:0]  d;
    logic [7:0]       st;
    int               per;
    int               wr;
    int               rdv;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!CS_n) cs_low++;
    if (CS_n && SCLK) sclk_cs_err++;
    if (SCLK != sclk_prev) begin
      if (seen_tog && run_len != CLK_DIV) hp_err++;
      seen_tog = 1'b1;
      run_len  = 1;
      if (SCLK) begin
        rises++;
        got_mosi.push_back(MOSI);
      end
    end else begin
      run_len++;
      if (SCLK && MOSI != mosi_prev) mosi_err++;
    end
    sclk_prev = SCLK;
    mosi_prev = MOSI;
    if (wr_req) begin
      wr_cnt++;
      wr_data = (wr_q.size() > 0) ? wr_q.pop_front() : 8'h00;
    end
    if (rd_valid) got_rd.push_back(rd_data);
    if (done) done_cnt++;
  endtask

  // Reference model: expected MOSI bit stream, read bytes and write-byte supply.
  task automatic prep(input logic [7:0] h, input logic [7:0] l, input logic [0:7][7:0] d,
                      input logic [7:0] st);
    exp_mosi.delete(); got_mosi.delete(); exp_rd.delete(); got_rd.delete(); wr_q.delete();
    for (int i = 7; i >= 0; i--) exp_mosi.push_back(h[i]);
    miso_vec = '0;
    for (int i = 0; i < 8; i++) miso_vec[i] = st[7-i];
    for (int b = 0; b < int'(l); b++) begin
      for (int i = 7; i >= 0; i--) begin
        exp_mosi.push_back(h[7] ? 1'b0 : d[b][i]);
        miso_vec[8 + 8*b + (7-i)] = d[b][i];
      end
      if (h[7]) exp_rd.push_back(d[b]);
      else      wr_q.push_back(d[b]);
    end
    sl_n = 8 * (int'(l) + 1);
    rises = 0; cs_low = 0; hp_err = 0; mosi_err = 0; sclk_cs_err = 0;
    wr_cnt = 0; done_cnt = 0; run_len = 0; seen_tog = 1'b0;
    header = h;
    len    = l;
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check({nm, ".done_seen"}, ok, 1);
  endtask

  task automatic check_txn(input string nm, input int per, input int wr, input int rdv,
                           input logic [7:0] st);
    int mism, n;
    check({nm, ".sclk_periods"}, rises, per);
    check({nm, ".mosi_len"}, got_mosi.size(), exp_mosi.size());
    mism = 0;
    n = (got_mosi.size() < exp_mosi.size()) ? got_mosi.size() : exp_mosi.size();
    for (int i = 0; i < n; i++) if (got_mosi[i] != exp_mosi[i]) mism++;
    check({nm, ".mosi_bits_wrong"}, mism, 0);
    check({nm, ".wr_req_pulses"}, wr_cnt, wr);
    check({nm, ".rd_valid_pulses"}, got_rd.size(), rdv);
    mism = 0;
    n = (got_rd.size() < exp_rd.size()) ? got_rd.size() : exp_rd.size();
    for (int i = 0; i < n; i++) if (got_rd[i] !== exp_rd[i]) mism++;
    check({nm, ".rd_data_wrong"}, mism, 0);
    check({nm, ".status"}, status, st);
    check({nm, ".done_pulses"}, done_cnt, 1);
    check({nm, ".half_period_err"}, hp_err, 0);
    check({nm, ".mosi_change_high"}, mosi_err, 0);
    check({nm, ".sclk_while_cs_high"}, sclk_cs_err, 0);
    check({nm, ".cs_low_min"}, cs_low >= 2*CLK_DIV*(per + 1), 1);
    check({nm, ".end_cs_busy_sclk_to"}, {CS_n, busy, SCLK, timeout_err}, 4'b1000);
    last_status = st;
  endtask

  task automatic run(input string nm, input logic [7:0] h, input logic [7:0] l,
                     input logic [0:7][7:0] d, input logic [7:0] st,
                     input int per, input int wr, input int rdv);
    prep(h, l, d, st);
    launch();
    wait_done(nm, 2*CLK_DIV*(8*(int'(l) + 1) + 4) + 40);
    repeat (3) tick();
    check_txn(nm, per, wr, rdv, st);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int   to_tick;
    bit   ok;

    vecs[0] = '{"write_01",    8'h01, 8'd2, {8'hA5, 8'h3C, 48'h0},        8'h0F, 24, 2, 0};
    vecs[1] = '{"read_81",     8'h81, 8'd1, {8'h5A, 56'h0},               8'h0F, 16, 0, 1};
    vecs[2] = '{"strobe_36",   8'h36, 8'd0, 64'h0,                        8'h2A,  8, 0, 0};
    vecs[3] = '{"burst_wr_45", 8'h45, 8'd3, {8'h11, 8'h22, 8'h33, 40'h0}, 8'h05, 32, 3, 0};
    vecs[4] = '{"burst_rd_ca", 8'hCA, 8'd3, {8'h80, 8'hFF, 8'h01, 40'h0}, 8'h7F, 32, 0, 3};
    vecs[5] = '{"rd_strobe_b5",8'hB5, 8'd0, 64'h0,                        8'h60,  8, 0, 0};

    rst = 1'b1; start = 1'b0; header = '0; len = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("reset.pins", {CS_n, SCLK, MOSI}, 3'b100);
    check("reset.flags", {busy, done, wr_req, rd_valid, timeout_err}, 5'b0);
    check("reset.data", {status, rd_data}, 16'h0);
    rst = 1'b0;
    repeat (2) tick();

    foreach (vecs[i])
      run(vecs[i].nm, vecs[i].h, vecs[i].l, vecs[i].d, vecs[i].st,
          vecs[i].per, vecs[i].wr, vecs[i].rdv);

    for (int t = 0; t < 8; t++) begin
      logic [7:0]      h, l, st;
      logic [0:7][7:0] d;
      h  = 8'($urandom());
      l  = 8'($urandom_range(0, 5));
      st = 8'($urandom()) & 8'h7F;
      d  = {$urandom(), $urandom()};
      run($sformatf("rand%0d", t), h, l, d, st, 8*(int'(l) + 1),
          h[7] ? 0 : int'(l), h[7] ? int'(l) : 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    // A start while busy is ignored; a start in the done cycle is accepted at once.
    prep(8'h2A, 8'd2, {8'hC3, 8'h5E, 48'h0}, 8'h11);
    launch();
    repeat (20) tick();
    header = 8'hFF; len = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_ignore", 400);
    check_txn("busy_ignore", 24, 2, 0, 8'h11);
    prep(8'h8A, 8'd2, {8'h9C, 8'h42, 48'h0}, 8'h33);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_start.cs_n_low", CS_n, 1'b0);
    check("done_start.busy", busy, 1'b1);
    wait_done("done_start", 400);
    repeat (3) tick();
    check_txn("done_start", 24, 0, 2, 8'h33);

    // MISO held high through the ready-wait window.
    prep(8'h01, 8'd0, 64'h0, 8'hFF);
    miso_hi = 1'b1;
    launch();
    to_tick = 0;
    ok = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (timeout_err && to_tick == 0) to_tick = i;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) tick();
    miso_hi = 1'b0;
    check("rdy.done_seen", ok, 1);
`ifdef CC1200_SPI_RDY_WAIT_EN
    check("rdy.timeout_when", (to_tick >= RDY_TIMEOUT) && (to_tick <= RDY_TIMEOUT + 2), 1);
    check("rdy.sclk_edges", rises, 0);
    check("rdy.wr_req_pulses", wr_cnt, 0);
    check("rdy.rd_valid_pulses", got_rd.size(), 0);
    check("rdy.status_kept", status, last_status);
    check("rdy.done_pulses", done_cnt, 1);
    check("rdy.end_cs_busy_sclk_to", {CS_n, busy, SCLK, timeout_err}, 4'b1001);
`else
    check("rdy.no_timeout", to_tick, 0);
    check_txn("rdy_ignored", 8, 0, 0, 8'hFF);
`endif

    // Asynchronous reset during bit 3 of data byte 1, then a clean transaction.
    prep(8'h01, 8'd2, {8'hA5, 8'h3C, 48'h0}, 8'h0F);
    launch();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (rises == 11) begin
        ok = 1'b1;
        break;
      end
    end
    check("midrst.reached_bit3", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst.pins", {CS_n, SCLK, MOSI}, 3'b100);
    check("midrst.flags", {busy, done, wr_req, rd_valid, timeout_err}, 5'b0);
    check("midrst.data", {status, rd_data}, 16'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("midrst.idle_cs", {CS_n, busy}, 2'b10);
    run("post_rst", 8'h01, 8'd1, {8'h77, 56'h0}, 8'h0F, 16, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
